// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: PC step, FSM state
// encodings and the default reset vector.
package fetch_pc_ctrl_pkg;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int unsigned PC_STEP = 4;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // BOOT: single idle cycle after reset.
    // RUN: sequential fetch from pc_q.
    // REDIR: a redirect target is held in redir_addr until the ROM accepts it.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_pc_ctrl_pc_fifo.sv
// Synchronous FIFO holding the PCs of issued-but-unreturned ROM requests.
// The head reads as EMPTY_VAL while the FIFO is empty so the observable
// output has a defined reset value without resetting the storage array.
module fetch_pc_ctrl_pc_fifo #(
    parameter int unsigned       DEPTH     = 2,
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  EMPTY_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [NW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write on push.
    // NOTE: the data array is deliberately not reset; the head is masked by
    // the occupancy count instead, so only the control registers need reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + NW'(push) - NW'(pop);
        end
    end

    assign head = (count == '0) ? EMPTY_VAL : mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Next-PC generator and fetch-request tracker for the pre-IF stage.
// Drives the instruction ROM address channel, holds redirects that arrive
// while the ROM is stalled, limits outstanding requests to MAX_OUT and
// drops wrong-path responses after a redirect.
// Optional feature macro: FETCH_PC_MISALIGN_CHK_EN (ignore jumps to
// non-word-aligned targets and flag them on misalign).
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int unsigned MAX_OUT   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           jump,
    input  logic [PC_WIDTH-1:0]            branch_addr,
    input  logic                           hold,
    input  logic                           fence,
    input  logic                           allow_in_if,
    output logic                           rom_req,
    output logic [PC_WIDTH-1:0]            rom_addr,
    input  logic                           mem_addr_ok,
    input  logic                           mem_data_ok,
    output logic                           resp_valid,
    output logic [PC_WIDTH-1:0]            resp_pc,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           misalign
);

    localparam int unsigned        CW     = $clog2(MAX_OUT + 1);
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VEC);
    localparam logic [CW-1:0]      CNT_MAX = CW'(MAX_OUT);

    state_e              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic [PC_WIDTH-1:0] redir_addr, redir_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [CW-1:0]       discard, discard_nxt;

    logic [PC_WIDTH-1:0] target;
    logic                take_jump;
    logic                stop;
    logic                accept;

`ifdef FETCH_PC_MISALIGN_CHK_EN
    logic misalign_q;
    logic target_misaligned;

    assign target_misaligned = (branch_addr[1:0] != 2'b00);
    assign target            = branch_addr;
    // A misaligned jump is dropped entirely: no redirect, no discard update.
    assign take_jump         = jump & !target_misaligned;

    // One-cycle flag for a rejected misaligned jump.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= jump & target_misaligned;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_branch_low;

    // Low target bits are ignored so every fetch stays word-aligned.
    assign target            = {branch_addr[PC_WIDTH-1:2], 2'b00};
    assign take_jump         = jump;
    assign unused_branch_low = ^branch_addr[1:0];
    assign misalign          = 1'b0;
`endif

    // State and datapath registers, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only; all
    // next-state values are computed in the combinational block below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            pc_q       <= RST_PC;
            redir_addr <= RST_PC;
            cnt        <= '0;
            discard    <= '0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            redir_addr <= redir_nxt;
            cnt        <= cnt_nxt;
            discard    <= discard_nxt;
        end
    end

    // Request generation, redirect capture, discard tracking and next state.
    // NOTE: every signal written here receives a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        redir_nxt   = redir_addr;
        discard_nxt = discard;

        stop    = fence | hold | !allow_in_if | (cnt == CNT_MAX) | (state == ST_BOOT);
        rom_req = !stop;

        // A fresh jump overrides a pending redirect; the target goes out the
        // same cycle so redirect latency is zero.
        if (take_jump) begin
            rom_addr = target;
        end else if (state == ST_REDIR) begin
            rom_addr = redir_addr;
        end else begin
            rom_addr = pc_q;
        end

        accept     = rom_req & mem_addr_ok;
        resp_valid = mem_data_ok & (discard == '0) & !take_jump;
        cnt_nxt    = cnt + CW'(accept) - CW'(mem_data_ok);

        if (accept) begin
            pc_nxt = rom_addr + PC_WIDTH'(PC_STEP);
        end

        if (take_jump) begin
            // Everything already in flight is wrong-path, except a response
            // returning this very cycle (it is dropped via !take_jump above).
            // A request accepted now carries the target and stays valid.
            discard_nxt = cnt - CW'(mem_data_ok);
            if (accept) begin
                state_nxt = ST_RUN;
            end else begin
                redir_nxt = target;
                state_nxt = ST_REDIR;
            end
        end else begin
            if (mem_data_ok && (discard != '0)) begin
                discard_nxt = discard - CW'(1);
            end
            case (state)
                ST_BOOT:  state_nxt = ST_RUN;
                ST_REDIR: state_nxt = accept ? ST_RUN : ST_REDIR;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    fetch_pc_ctrl_pc_fifo #(
        .DEPTH     (MAX_OUT),
        .WIDTH     (PC_WIDTH),
        .EMPTY_VAL (RST_PC)
    ) u_pc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (rom_addr),
        .pop   (mem_data_ok),
        .head  (resp_pc)
    );

    assign outstanding = cnt;

`ifndef SYNTHESIS
    // The ROM must never return data with nothing outstanding.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_data_ok && (cnt == '0)));
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl. A 32-bit instance (MAX_OUT=2, reset
// vector 0) exercises sequential fetch, redirects, stalls and reset; an
// 8-bit instance with reset vector 0xFC exercises PC wrap-around.
// Define FETCH_PC_MISALIGN_CHK_EN to check the misaligned-jump variant.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        jump;
    logic [31:0] branch_addr;
    logic        hold;
    logic        fence;
    logic        allow_in_if;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [1:0]  outstanding;
    logic        misalign;

    logic        w_rom_req;
    logic [7:0]  w_rom_addr;
    logic        w_resp_valid;
    logic [7:0]  w_resp_pc;
    logic [1:0]  w_outstanding;
    logic        w_misalign;

    int vectors     = 0;
    int miscompares = 0;

    fetch_pc_ctrl #(
        .PC_WIDTH  (32),
        .RESET_VEC (32'h0000_0000),
        .MAX_OUT   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump        (jump),
        .branch_addr (branch_addr),
        .hold        (hold),
        .fence       (fence),
        .allow_in_if (allow_in_if),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .resp_valid  (resp_valid),
        .resp_pc     (resp_pc),
        .outstanding (outstanding),
        .misalign    (misalign)
    );

    fetch_pc_ctrl #(
        .PC_WIDTH  (8),
        .RESET_VEC (32'h0000_00FC),
        .MAX_OUT   (2)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump        (1'b0),
        .branch_addr (8'h00),
        .hold        (1'b0),
        .fence       (1'b0),
        .allow_in_if (1'b1),
        .rom_req     (w_rom_req),
        .rom_addr    (w_rom_addr),
        .mem_addr_ok (1'b1),
        .mem_data_ok (1'b0),
        .resp_valid  (w_resp_valid),
        .resp_pc     (w_resp_pc),
        .outstanding (w_outstanding),
        .misalign    (w_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge; inputs are driven there and outputs
    // sampled 1 time unit later, well away from the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    logic [31:0] exp_misalign_addr;
    logic        exp_misalign_flag;

    initial begin
        rst_n       = 1'b0;
        jump        = 1'b0;
        branch_addr = 32'h0;
        hold        = 1'b0;
        fence       = 1'b0;
        allow_in_if = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b0;

        // Reset values after one reset edge.
        next_cycle(); #1;
        check("rst_rom_req",     32'(rom_req), 32'h0);
        check("rst_rom_addr",    rom_addr, 32'h0);
        check("rst_resp_valid",  32'(resp_valid), 32'h0);
        check("rst_resp_pc",     resp_pc, 32'h0);
        check("rst_outstanding", 32'(outstanding), 32'h0);
        check("rst_misalign",    32'(misalign), 32'h0);
        check("w_rst_rom_addr",  32'(w_rom_addr), 32'hFC);

        // C0: BOOT cycle, no request yet.
        next_cycle(); rst_n = 1'b1; #1;
        check("boot_rom_req",   32'(rom_req), 32'h0);
        check("w_boot_rom_req", 32'(w_rom_req), 32'h0);

        // C1: first request at the reset vector.
        next_cycle(); #1;
        check("c1_rom_req",    32'(rom_req), 32'h1);
        check("c1_rom_addr",   rom_addr, 32'h0);
        check("w_c1_rom_addr", 32'(w_rom_addr), 32'hFC);

        // C2..C4: free-running ROM, data one cycle behind the address.
        next_cycle(); mem_data_ok = 1'b1; #1;
        check("c2_rom_addr",    rom_addr, 32'h4);
        check("c2_resp_valid",  32'(resp_valid), 32'h1);
        check("c2_resp_pc",     resp_pc, 32'h0);
        check("c2_outstanding", 32'(outstanding), 32'h1);
        check("w_c2_wrap_addr", 32'(w_rom_addr), 32'h00);

        next_cycle(); #1;
        check("c3_rom_addr",   rom_addr, 32'h8);
        check("c3_resp_valid", 32'(resp_valid), 32'h1);
        check("c3_resp_pc",    resp_pc, 32'h4);
        check("w_c3_rom_req",  32'(w_rom_req), 32'h0);
        check("w_c3_outst",    32'(w_outstanding), 32'h2);

        next_cycle(); #1;
        check("c4_rom_addr", rom_addr, 32'hC);
        check("c4_resp_pc",  resp_pc, 32'h8);

        // C5: no return, pipeline fills to MAX_OUT.
        next_cycle(); mem_data_ok = 1'b0; #1;
        check("c5_rom_addr",    rom_addr, 32'h10);
        check("c5_outstanding", 32'(outstanding), 32'h1);

        // C6: full, jump to 0x100 captured as a pending redirect.
        next_cycle(); jump = 1'b1; branch_addr = 32'h100; #1;
        check("c6_rom_req",     32'(rom_req), 32'h0);
        check("c6_rom_addr",    rom_addr, 32'h100);
        check("c6_outstanding", 32'(outstanding), 32'h2);

        // C7/C8: both old responses are wrong-path; redirect issues at C8.
        next_cycle(); jump = 1'b0; mem_data_ok = 1'b1; #1;
        check("c7_rom_req",    32'(rom_req), 32'h0);
        check("c7_rom_addr",   rom_addr, 32'h100);
        check("c7_resp_valid", 32'(resp_valid), 32'h0);
        check("c7_resp_pc",    resp_pc, 32'hC);

        next_cycle(); #1;
        check("c8_rom_req",     32'(rom_req), 32'h1);
        check("c8_rom_addr",    rom_addr, 32'h100);
        check("c8_resp_valid",  32'(resp_valid), 32'h0);
        check("c8_resp_pc",     resp_pc, 32'h10);
        check("c8_outstanding", 32'(outstanding), 32'h1);

        // C9/C10: correct-path responses resume from the target.
        next_cycle(); #1;
        check("c9_rom_addr",   rom_addr, 32'h104);
        check("c9_resp_valid", 32'(resp_valid), 32'h1);
        check("c9_resp_pc",    resp_pc, 32'h100);

        next_cycle(); mem_addr_ok = 1'b0; #1;
        check("c10_rom_addr",   rom_addr, 32'h108);
        check("c10_resp_valid", 32'(resp_valid), 32'h1);
        check("c10_resp_pc",    resp_pc, 32'h104);

        // C11..C13: jump to 0x200 during a three-cycle hold.
        next_cycle(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; hold = 1'b1;
        jump = 1'b1; branch_addr = 32'h200; #1;
        check("c11_rom_req",     32'(rom_req), 32'h0);
        check("c11_rom_addr",    rom_addr, 32'h200);
        check("c11_outstanding", 32'(outstanding), 32'h0);

        next_cycle(); jump = 1'b0; #1;
        check("c12_rom_req",  32'(rom_req), 32'h0);
        check("c12_rom_addr", rom_addr, 32'h200);

        next_cycle(); #1;
        check("c13_rom_req", 32'(rom_req), 32'h0);

        // C14: hold drops, held target issues this cycle.
        next_cycle(); hold = 1'b0; #1;
        check("c14_rom_req",  32'(rom_req), 32'h1);
        check("c14_rom_addr", rom_addr, 32'h200);

        // C15: back in RUN, sequential from the target.
        next_cycle(); mem_data_ok = 1'b1; #1;
        check("c15_rom_addr",   rom_addr, 32'h204);
        check("c15_resp_valid", 32'(resp_valid), 32'h1);
        check("c15_resp_pc",    resp_pc, 32'h200);

        // C16: jump accepted immediately while an old response returns.
        next_cycle(); jump = 1'b1; branch_addr = 32'h300; #1;
        check("c16_rom_req",    32'(rom_req), 32'h1);
        check("c16_rom_addr",   rom_addr, 32'h300);
        check("c16_resp_valid", 32'(resp_valid), 32'h0);
        check("c16_resp_pc",    resp_pc, 32'h204);

        // C17: request issued in the jump cycle is correct-path.
        next_cycle(); jump = 1'b0; mem_addr_ok = 1'b0; #1;
        check("c17_resp_valid", 32'(resp_valid), 32'h1);
        check("c17_resp_pc",    resp_pc, 32'h300);
        check("c17_rom_addr",   rom_addr, 32'h304);

        // C18..C20: fence and IF back-pressure gate the request.
        next_cycle(); mem_data_ok = 1'b0; fence = 1'b1; #1;
        check("c18_fence_req",  32'(rom_req), 32'h0);
        check("c18_outstanding", 32'(outstanding), 32'h0);

        next_cycle(); fence = 1'b0; allow_in_if = 1'b0; #1;
        check("c19_allow_req", 32'(rom_req), 32'h0);

        next_cycle(); allow_in_if = 1'b1; #1;
        check("c20_rom_req",  32'(rom_req), 32'h1);
        check("c20_rom_addr", rom_addr, 32'h304);

        // C21..C23: jump to a target with nonzero low bits.
`ifdef FETCH_PC_MISALIGN_CHK_EN
        branch_addr       = 32'h102;
        exp_misalign_addr = 32'h304;
        exp_misalign_flag = 1'b1;
`else
        branch_addr       = 32'h403;
        exp_misalign_addr = 32'h400;
        exp_misalign_flag = 1'b0;
`endif
        next_cycle(); jump = 1'b1; #1;
        check("c21_rom_addr", rom_addr, exp_misalign_addr);
        check("c21_misalign", 32'(misalign), 32'h0);

        next_cycle(); jump = 1'b0; #1;
        check("c22_rom_addr", rom_addr, exp_misalign_addr);
        check("c22_misalign", 32'(misalign), 32'(exp_misalign_flag));

        next_cycle(); mem_addr_ok = 1'b1; #1;
        check("c23_misalign",    32'(misalign), 32'h0);
        check("c23_outstanding", 32'(outstanding), 32'h0);

        // C24: one request in flight, then reset mid-operation.
        next_cycle(); rst_n = 1'b0; #1;
        check("c24_rom_addr",    rom_addr, exp_misalign_addr + 32'h4);
        check("c24_outstanding", 32'(outstanding), 32'h1);

        next_cycle(); rst_n = 1'b1; mem_addr_ok = 1'b0; #1;
        check("mid_rst_rom_req",  32'(rom_req), 32'h0);
        check("mid_rst_rom_addr", rom_addr, 32'h0);
        check("mid_rst_outst",    32'(outstanding), 32'h0);
        check("mid_rst_resp_pc",  resp_pc, 32'h0);
        check("w_mid_rst_outst",  32'(w_outstanding), 32'h0);
        check("w_mid_rst_addr",   32'(w_rom_addr), 32'hFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Parametrised next-PC generator and fetch-request tracker. Sits in the pre-IF stage and drives the instruction ROM address channel. It keeps a registered PC and holds redirects that arrive while the ROM is stalled. It allows up to MAX_OUT outstanding fetches and discards wrong-path responses after a redirect, handing the IF stage each valid response together with its PC.

## Interface
- PC_WIDTH, 32: PC/address width in bits (≥ 8).
- RESET_VEC, 32'h0000_0000: first fetch address after reset, truncated to PC_WIDTH.
- MAX_OUT, 2: maximum outstanding ROM requests (1..8).
- CW: localparam, $clog2(MAX_OUT+1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- jump  in  1  redirect request from EX.
- branch_addr  in  PC_WIDTH  redirect target.
- hold  in  1  pipeline hold.
- fence  in  1  fence stall.
- allow_in_if  in  1  IF stage can accept.
- rom_req  out  1  ROM address request.
- rom_addr  out  PC_WIDTH  ROM fetch address.
- mem_addr_ok  in  1  ROM accepted address this cycle.
- mem_data_ok  in  1  ROM returned data this cycle (in order).
- resp_valid  out  1  returned data is correct-path.
- resp_pc  out  PC_WIDTH  PC of the current response.
- outstanding  out  CW  issued-but-unreturned count.
- misalign  out  1  misaligned target flag (macro only).

## Operation
- States: BOOT, RUN, REDIR. BOOT lasts exactly one cycle after reset, then → RUN. RUN → REDIR on jump not accepted the same cycle. REDIR → RUN on accept.
- Registers: pc_q, redir_addr, cnt, discard, state.
- stop = fence | hold | !allow_in_if | (cnt == MAX_OUT) | state==BOOT.
- rom_req = !stop.
- rom_addr = jump ? branch_addr : (state==REDIR ? redir_addr : pc_q). jump has priority over a pending redir.
- accept = rom_req & mem_addr_ok.
  - On accept: pc_q ← rom_addr + 4 (mod 2^PC_WIDTH, wraps silently), rom_addr pushed into pc FIFO.
  - jump without accept: redir_addr ← branch_addr, state ← REDIR.
- cnt ← cnt + accept − mem_data_ok. Simultaneous accept and data_ok leaves cnt unchanged. mem_data_ok with cnt==0 is illegal (assertion).
- Discard on jump: discard ← cnt − mem_data_ok. Requests accepted in the jump cycle carry branch_addr and are correct-path.
- Discard otherwise: discard decrements on mem_data_ok while nonzero.
- resp_valid = mem_data_ok & (discard == 0) & !jump.
- resp_pc = pc FIFO head, popped on every mem_data_ok (valid or discarded).
- hold/fence/allow_in_if never drop a jump; it is always captured.

## Timing
- Reset values: rom_req 0, rom_addr RESET_VEC, pc_q RESET_VEC, state BOOT, cnt 0, discard 0, resp_valid 0, resp_pc RESET_VEC, misalign 0.
- rom_req, rom_addr and resp_valid are combinational from registers plus current-cycle inputs: zero-cycle redirect latency.
- First request can be issued in the second cycle after rst_n rises.
- Issue rate: 1 request/cycle sustained when mem_addr_ok stays high and cnt < MAX_OUT.
- Reset asserted mid-operation clears all state next edge. In-flight responses are ignored only if ROM is reset together (system requirement).

## Configuration
- FETCH_PC_MISALIGN_CHK_EN defined:
  - A jump with branch_addr[1:0] ≠ 0 is not followed: no redirect, no discard update.
  - misalign is registered high for one cycle.
  - Fetch continues from pc_q.
- Undefined: branch_addr[1:0] forced to 0, misalign tied 0.

## Structure
- Shared package/include: PC step constant (4), state encodings BOOT/RUN/REDIR, RESET_VEC default.
- Sub-module: pc_fifo. Synchronous FIFO, depth MAX_OUT, width PC_WIDTH, push/pop/head. Same clk/rst_n.

## Test plan
- Reset then free-running ROM (addr_ok=1, data_ok one cycle later, MAX_OUT=2): rom_addr 0x0, 0x4, 0x8…; resp_pc matches each address; resp_valid every response.
- jump to 0x100 with 2 outstanding: those 2 responses have resp_valid=0; next valid resp_pc=0x100, then 0x104.
- jump to 0x200 while hold=1 for 3 cycles: rom_req=0; after hold drops rom_addr=0x200 in that cycle; state returns to RUN.
- mem_addr_ok=0 with cnt==MAX_OUT: rom_req deasserts; single data_ok re-enables next request; cnt never exceeds MAX_OUT.
- PC_WIDTH=8, pc_q=0xFC: next fetch 0x00 (wrap).
- With FETCH_PC_MISALIGN_CHK_EN, jump to 0x102: misalign pulses 1 cycle; fetch continues sequentially; no discard.
